// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester round-robin controller for the 4-bit shift
// register. It accepts one command at a time, then issues `cnt` single-cycle
// shift pulses, each separated by GAP idle cycles. It ends every command with a
// one-cycle done pulse that carries the owner id and an abort flag.
module shift_sequencer #(
    parameter int CNT_W = 3,
    parameter int GAP   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_dir,
    input  logic [2*CNT_W-1:0] req_cnt,
    output logic [1:0]         req_ready,
    input  logic               abort,
    output logic               shift_left,
    output logic               shift_right,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic               done_aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic             rr_ptr;
    logic             dir;
    logic             owner;
    logic             aborted;
    logic [CNT_W-1:0] remaining;
    logic [3:0]       gap_cnt;

    logic             grant_any;
    logic             grant_id;
    logic [CNT_W-1:0] grant_cnt;

    // Pick the winning requester. rr_ptr breaks ties only when both requesters are valid.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = (&req_valid) ? rr_ptr : req_valid[1];
        grant_cnt = grant_id ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
        req_ready = 2'b00;
        if (state == S_IDLE && !rst && grant_any) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Command sequencing: accept, pulse/gap loop, then a done cycle that hands priority to the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= 1'b0;
            remaining <= '0;
            gap_cnt   <= 4'd0;
            dir       <= 1'b0;
            owner     <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        dir     <= req_dir[grant_id];
                        owner   <= grant_id;
                        aborted <= 1'b0;
                        if (grant_cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            remaining <= grant_cnt;
                            state     <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= S_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt <= 4'(GAP);
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                        if (gap_cnt == 4'd1) begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_DONE: begin
                    rr_ptr <= ~owner;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode. An abort raised during a SHIFT cycle suppresses the pulse in that same cycle.
    always_comb begin
        shift_left   = (state == S_SHIFT) && !abort && !dir;
        shift_right  = (state == S_SHIFT) && !abort && dir;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        done_id      = (state == S_DONE) && owner;
        done_aborted = (state == S_DONE) && aborted;
    end

endmodule
